// File: rtl/wb_addr_patch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_addr_patch_ctrl
// Description : Wishbone-style address-patch controller. A small table of
//               {enable, address, data} entries is programmed through a config
//               port. Slave reads that hit an enabled entry are answered
//               locally with the patch data. Slave writes that hit an enabled
//               entry are acknowledged and dropped. Every other cycle is
//               forwarded to the master port under a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_addr_patch_ctrl #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int NUM_PATCH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  // slave port (CPU side)
  input  logic                         si_cyc_i,
  input  logic                         si_stb_i,
  input  logic                         si_we_i,
  input  logic [AW-1:0]                si_addr_i,
  input  logic [DW-1:0]                si_dat_i,
  output logic [DW-1:0]                si_dat_o,
  output logic                         si_ack_o,
  output logic                         si_err_o,
  // master port (memory side)
  output logic                         mi_cyc_o,
  output logic                         mi_stb_o,
  output logic                         mi_we_o,
  output logic [AW-1:0]                mi_addr_o,
  output logic [DW-1:0]                mi_dat_o,
  input  logic [DW-1:0]                mi_dat_i,
  input  logic                         mi_ack_i,
  // patch table config port
  input  logic                         cfg_we_i,
  input  logic [$clog2(NUM_PATCH)-1:0] cfg_idx_i,
  input  logic                         cfg_en_i,
  input  logic [AW-1:0]                cfg_addr_i,
  input  logic [DW-1:0]                cfg_data_i,
  output logic [15:0]                  patch_hit_cnt_o
);

  localparam int          CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [15:0] HIT_MAX = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_PATCH  = 3'd2,
    S_FWD    = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t                       state_q, state_d;
  logic                         we_q, we_d;
  logic [AW-1:0]                addr_q, addr_d;
  logic [DW-1:0]                wdat_q, wdat_d;
  logic [DW-1:0]                rdat_q, rdat_d;
  logic [CW-1:0]                tcnt_q, tcnt_d;
  logic                         err_q, err_d;
  logic [15:0]                  hit_cnt_q, hit_cnt_d;

  logic [NUM_PATCH-1:0]         tab_en_q, tab_en_d;
  logic [NUM_PATCH-1:0][AW-1:0] tab_addr_q, tab_addr_d;
  logic [NUM_PATCH-1:0][DW-1:0] tab_data_q, tab_data_d;

  logic                         hit;
  logic [DW-1:0]                hit_data;

  // Table update: a config write lands at the clock edge, so any lookup in the
  // same cycle still compares against the old contents.
  always_comb begin
    tab_en_d   = tab_en_q;
    tab_addr_d = tab_addr_q;
    tab_data_d = tab_data_q;
    if (cfg_we_i) begin
      tab_en_d[cfg_idx_i]   = cfg_en_i;
      tab_addr_d[cfg_idx_i] = cfg_addr_i;
      tab_data_d[cfg_idx_i] = cfg_data_i;
    end
  end

  // Priority match: scan from the top index down so the lowest index wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NUM_PATCH - 1; i >= 0; i--) begin
      if (tab_en_q[i] && (tab_addr_q[i] == addr_q)) begin
        hit      = 1'b1;
        hit_data = tab_data_q[i];
      end
    end
  end

  // Transaction sequencer: next state, captured request, response data, counters.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    rdat_d    = rdat_q;
    tcnt_d    = tcnt_q;
    err_d     = 1'b0;
    hit_cnt_d = hit_cnt_q;
    si_ack_o  = 1'b0;
    mi_cyc_o  = 1'b0;
    mi_stb_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (si_cyc_i && si_stb_i) begin
          we_d    = si_we_i;
          addr_d  = si_addr_i;
          wdat_d  = si_dat_i;
          state_d = S_LOOKUP;
        end
      end

      S_LOOKUP: begin
        if (!si_cyc_i) begin
          state_d = S_IDLE;
        end else if (hit) begin
          // Load the patch data now so it is valid during the ack cycle.
          if (!we_q) rdat_d = hit_data;
          state_d = S_PATCH;
        end else begin
          tcnt_d  = '0;
          state_d = S_FWD;
        end
      end

      S_PATCH: begin
        si_ack_o = 1'b1;
        if (!we_q && (hit_cnt_q != HIT_MAX)) hit_cnt_d = hit_cnt_q + 16'd1;
        state_d = S_IDLE;
      end

      S_FWD: begin
        mi_cyc_o = 1'b1;
        mi_stb_o = 1'b1;
        if (!si_cyc_i) begin
          state_d = S_IDLE;
        end else if (mi_ack_i) begin
          if (!we_q) rdat_d = mi_dat_i;
          state_d = S_RESP;
        end else if (tcnt_q == TO_LAST) begin
          // TIMEOUT strobe cycles elapsed; the error pulse follows in IDLE.
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end

      S_RESP: begin
        si_ack_o = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      tcnt_q     <= '0;
      err_q      <= 1'b0;
      hit_cnt_q  <= '0;
      tab_en_q   <= '0;
      tab_addr_q <= '0;
      tab_data_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rdat_q     <= rdat_d;
      tcnt_q     <= tcnt_d;
      err_q      <= err_d;
      hit_cnt_q  <= hit_cnt_d;
      tab_en_q   <= tab_en_d;
      tab_addr_q <= tab_addr_d;
      tab_data_q <= tab_data_d;
    end
  end

  assign si_dat_o        = rdat_q;
  assign si_err_o        = err_q;
  assign mi_we_o         = we_q;
  assign mi_addr_o       = addr_q;
  assign mi_dat_o        = wdat_q;
  assign patch_hit_cnt_o = hit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_addr_patch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_addr_patch_ctrl
// Description : Directed plus randomized bench for wb_addr_patch_ctrl. A
//               table-level reference model predicts patch or forward,
//               response data and the hit count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_addr_patch_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          si_cyc_i = 1'b0, si_stb_i = 1'b0, si_we_i = 1'b0;
  logic [AW-1:0] si_addr_i = '0;
  logic [DW-1:0] si_dat_i = '0;
  logic [DW-1:0] si_dat_o;
  logic          si_ack_o, si_err_o;
  logic          mi_cyc_o, mi_stb_o, mi_we_o;
  logic [AW-1:0] mi_addr_o;
  logic [DW-1:0] mi_dat_o;
  logic [DW-1:0] mi_dat_i = '0;
  logic          mi_ack_i = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [1:0]    cfg_idx_i = '0;
  logic          cfg_en_i = 1'b0;
  logic [AW-1:0] cfg_addr_i = '0;
  logic [DW-1:0] cfg_data_i = '0;
  logic [15:0]   patch_hit_cnt_o;

  wb_addr_patch_ctrl #(.AW(AW), .DW(DW), .NUM_PATCH(NP), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .si_cyc_i(si_cyc_i), .si_stb_i(si_stb_i), .si_we_i(si_we_i),
    .si_addr_i(si_addr_i), .si_dat_i(si_dat_i), .si_dat_o(si_dat_o),
    .si_ack_o(si_ack_o), .si_err_o(si_err_o),
    .mi_cyc_o(mi_cyc_o), .mi_stb_o(mi_stb_o), .mi_we_o(mi_we_o),
    .mi_addr_o(mi_addr_o), .mi_dat_o(mi_dat_o), .mi_dat_i(mi_dat_i),
    .mi_ack_i(mi_ack_i),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_en_i(cfg_en_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .patch_hit_cnt_o(patch_hit_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic          m_en   [NP];
  logic [AW-1:0] m_addr [NP];
  logic [DW-1:0] m_data [NP];
  logic [15:0]   m_cnt;
  logic [DW-1:0] m_sidat;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_en[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0;
    end
    m_cnt   = '0;
    m_sidat = '0;
  endtask

  // First enabled entry matching the address, or -1.
  function automatic int model_lookup(input logic [AW-1:0] a);
    for (int i = 0; i < NP; i++)
      if (m_en[i] && m_addr[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    logic [AW-1:0] pool [4] = '{32'h40, 32'h100, 32'h200, 32'h300};
    if ($urandom_range(0, 4) == 0) return $urandom;
    return pool[$urandom_range(0, 3)];
  endfunction

  task automatic cfg_write(input int idx, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we_i = 1'b1; cfg_idx_i = 2'(idx); cfg_en_i = en; cfg_addr_i = a; cfg_data_i = d;
    tick();
    cfg_we_i = 1'b0;
    m_en[idx] = en; m_addr[idx] = a; m_data[idx] = d;
  endtask

  // One complete slave transaction; the model decides patch versus forward.
  task automatic bus_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          input int ack_dly, input logic [DW-1:0] rd);
    int hi;
    hi = model_lookup(a);
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_we_i = we; si_addr_i = a; si_dat_i = wd;
    tick();
    si_stb_i = 1'b0;
    check("lookup_no_mcyc", {63'd0, mi_cyc_o}, 64'd0);
    check("lookup_no_ack", {63'd0, si_ack_o}, 64'd0);
    tick();
    if (hi >= 0) begin
      if (!we) begin
        m_sidat = m_data[hi];
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
      check("patch_ack", {63'd0, si_ack_o}, 64'd1);
      check("patch_no_mcyc", {63'd0, mi_cyc_o}, 64'd0);
      check("patch_dat", {32'd0, si_dat_o}, {32'd0, m_sidat});
      si_cyc_i = 1'b0;
      tick();
    end else begin
      check("fwd_cyc_stb", {62'd0, mi_cyc_o, mi_stb_o}, 64'd3);
      check("fwd_addr", {32'd0, mi_addr_o}, {32'd0, a});
      check("fwd_we", {63'd0, mi_we_o}, {63'd0, we});
      if (we) check("fwd_wdat", {32'd0, mi_dat_o}, {32'd0, wd});
      for (int k = 0; k < ack_dly; k++) begin
        tick();
        check("fwd_hold", {62'd0, mi_stb_o, si_ack_o}, 64'd2);
      end
      mi_ack_i = 1'b1; mi_dat_i = rd;
      tick();
      mi_ack_i = 1'b0; mi_dat_i = $urandom;
      if (!we) m_sidat = rd;
      check("resp_ack", {63'd0, si_ack_o}, 64'd1);
      check("resp_stb_low", {63'd0, mi_stb_o}, 64'd0);
      check("resp_dat", {32'd0, si_dat_o}, {32'd0, m_sidat});
      si_cyc_i = 1'b0;
      tick();
    end
    check("idle_ack_low", {63'd0, si_ack_o}, 64'd0);
    check("hit_cnt", {48'd0, patch_hit_cnt_o}, {48'd0, m_cnt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stb_cycles;
    logic saw_err;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outputs", {58'd0, si_ack_o, si_err_o, mi_cyc_o, mi_stb_o, mi_we_o, |mi_addr_o}, 64'd0);
    check("rst_dat", {32'd0, si_dat_o}, 64'd0);
    check("rst_cnt", {48'd0, patch_hit_cnt_o}, 64'd0);
    rst_ni = 1'b1;
    tick();

    // Patched read
    cfg_write(1, 1'b1, 32'h100, 32'hDEADBEEF);
    bus_xfer(1'b0, 32'h100, 32'h0, 0, 32'h0);
    check("patched_dat", {32'd0, si_dat_o}, 64'hDEADBEEF);
    check("cnt_one", {48'd0, patch_hit_cnt_o}, 64'd1);

    // Forwarded read, master acks three cycles after strobe
    bus_xfer(1'b0, 32'h200, 32'h0, 3, 32'h12345678);
    check("fwd_dat", {32'd0, si_dat_o}, 64'h12345678);

    // Multiple hits: lowest index wins
    cfg_write(0, 1'b1, 32'h40, 32'hA);
    cfg_write(2, 1'b1, 32'h40, 32'hB);
    bus_xfer(1'b0, 32'h40, 32'h0, 0, 32'h0);
    check("prio_low", {32'd0, si_dat_o}, 64'hA);
    cfg_write(0, 1'b0, 32'h40, 32'hA);
    bus_xfer(1'b0, 32'h40, 32'h0, 0, 32'h0);
    check("prio_next", {32'd0, si_dat_o}, 64'hB);

    // Write hits are dropped; after disabling the entry they are forwarded
    bus_xfer(1'b1, 32'h100, 32'hCAFE0001, 0, 32'h0);
    cfg_write(1, 1'b0, 32'h100, 32'hDEADBEEF);
    bus_xfer(1'b1, 32'h100, 32'hCAFE0002, 1, 32'h0);

    // Config write in the lookup cycle: lookup still sees the old table
    cfg_write(3, 1'b1, 32'h300, 32'h33);
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_we_i = 1'b0; si_addr_i = 32'h300;
    tick();
    si_stb_i = 1'b0;
    cfg_we_i = 1'b1; cfg_idx_i = 2'd3; cfg_en_i = 1'b0; cfg_addr_i = 32'h300; cfg_data_i = '0;
    tick();
    cfg_we_i = 1'b0;
    m_sidat = 32'h33; m_cnt = m_cnt + 16'd1;
    m_en[3] = 1'b0; m_data[3] = '0;
    check("samecyc_ack", {63'd0, si_ack_o}, 64'd1);
    check("samecyc_dat", {32'd0, si_dat_o}, 64'h33);
    si_cyc_i = 1'b0;
    tick();
    bus_xfer(1'b0, 32'h300, 32'h0, 2, 32'h5A5A5A5A);

    // Timeout: master never acks
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_we_i = 1'b0; si_addr_i = 32'h777;
    tick();
    si_stb_i = 1'b0;
    tick();
    stb_cycles = 0; saw_err = 1'b0;
    for (int k = 0; k < 20 && !saw_err; k++) begin
      if (mi_stb_o) stb_cycles++;
      if (si_err_o) saw_err = 1'b1;
      check("to_no_ack", {63'd0, si_ack_o}, 64'd0);
      if (!saw_err) tick();
    end
    check("to_stb_cycles", stb_cycles, TO);
    check("to_err_seen", {63'd0, saw_err}, 64'd1);
    check("to_err_stb_low", {63'd0, mi_stb_o}, 64'd0);
    si_cyc_i = 1'b0;
    tick();
    check("to_err_pulse", {62'd0, si_err_o, mi_stb_o}, 64'd0);

    // Abort in FWD
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_addr_i = 32'h888;
    tick();
    si_stb_i = 1'b0;
    tick();
    check("abort_fwd_stb", {63'd0, mi_stb_o}, 64'd1);
    tick();
    si_cyc_i = 1'b0;
    tick();
    check("abort_fwd_idle", {61'd0, mi_stb_o, si_ack_o, si_err_o}, 64'd0);
    mi_ack_i = 1'b1;
    tick();
    mi_ack_i = 1'b0;
    check("stray_ack_ignored", {61'd0, mi_stb_o, si_ack_o, si_err_o}, 64'd0);
    tick();
    check("abort_quiet", {62'd0, si_ack_o, si_err_o}, 64'd0);

    // Abort in LOOKUP
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_addr_i = 32'h40;
    tick();
    si_stb_i = 1'b0; si_cyc_i = 1'b0;
    tick();
    check("abort_lookup", {61'd0, mi_cyc_o, si_ack_o, si_err_o}, 64'd0);
    tick();
    check("abort_lookup_cnt", {48'd0, patch_hit_cnt_o}, {48'd0, m_cnt});

    // Randomized mix of config writes and transactions
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, NP - 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom);
      else
        bus_xfer(1'($urandom_range(0, 1)), pick_addr(), $urandom, int'($urandom_range(0, TO - 1)), $urandom);
    end

    // Saturation: preload the counter just below its maximum
    cfg_write(0, 1'b1, 32'h500, 32'h5555);
    force dut.hit_cnt_q = 16'hFFFD;
    tick();
    tick();
    release dut.hit_cnt_q;
    m_cnt = 16'hFFFD;
    for (int n = 0; n < 4; n++) bus_xfer(1'b0, 32'h500, 32'h0, 0, 32'h0);
    check("sat_cnt", {48'd0, patch_hit_cnt_o}, 64'hFFFF);

    // Reset in the middle of a forwarded cycle
    si_cyc_i = 1'b1; si_stb_i = 1'b1; si_we_i = 1'b0; si_addr_i = 32'h999;
    tick();
    si_stb_i = 1'b0;
    tick();
    check("prerst_cyc", {63'd0, mi_cyc_o}, 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_async_drop", {62'd0, mi_cyc_o, mi_stb_o}, 64'd0);
    model_reset();
    si_cyc_i = 1'b0;
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    tick();
    check("rst_cnt_clear", {48'd0, patch_hit_cnt_o}, 64'd0);
    check("rst_dat_clear", {32'd0, si_dat_o}, 64'd0);
    bus_xfer(1'b0, 32'h500, 32'h0, 1, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
